// File: rtl/uart_miner_comm.sv
`default_nettype none
// ============================================================================
//  Module      : uart_miner_comm
//  Description : 8N1 UART host link for the mining core. It parses CRC-32
//                framed commands, publishes jobs and reports golden nonces.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_miner_comm #(
    parameter int BAUD_RATE    = 115200,
    parameter int SYS_CLK_FREQ = 50000000
) (
    input  logic         comm_clk,
    input  logic         rst_n,
    input  logic         rx_serial,
    output logic         tx_serial,
    output logic         new_work,
    output logic [95:0]  work_data,
    output logic [31:0]  nonce_min,
    output logic [31:0]  nonce_max,
    output logic [255:0] midstate,
    input  logic         new_golden_nonce,
    input  logic [31:0]  golden_nonce
);
    localparam logic [15:0] C_CPB  = 16'(SYS_CLK_FREQ / BAUD_RATE);
    localparam logic [15:0] C_HALF = C_CPB >> 1;

    localparam logic [1:0] C_RB_IDLE = 2'd0, C_RB_START = 2'd1, C_RB_DATA = 2'd2, C_RB_STOP = 2'd3;
    localparam logic [2:0] C_FS_IDLE = 3'd0, C_FS_HDR = 3'd1, C_FS_PAYLOAD = 3'd2,
                           C_FS_CRC = 3'd3, C_FS_DISPATCH = 3'd4;
    localparam logic [2:0] C_MSG_PONG = 3'd0, C_MSG_INFO = 3'd1, C_MSG_INVALID = 3'd2,
                           C_MSG_ACK = 3'd3, C_MSG_NONCE = 3'd4;
    localparam logic [1:0] C_TS_IDLE = 2'd0, C_TS_START = 2'd1, C_TS_DATA = 2'd2, C_TS_STOP = 2'd3;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [7:0] msg_byte(input logic [2:0] kind, input logic [3:0] idx,
                                            input logic [31:0] n);
        logic [7:0] b;
        b = 8'h00;
        if (kind == C_MSG_PONG) begin
            b = 8'h01;
        end else if (kind == C_MSG_INFO) begin
            case (idx)
                4'd0:  b = 8'h10;
                4'd4:  b = 8'hde;
                4'd5:  b = 8'had;
                4'd6:  b = 8'hbe;
                4'd7:  b = 8'hef;
                4'd8:  b = 8'h13;
                4'd9:  b = 8'h37;
                4'd10: b = 8'h0d;
                4'd11: b = 8'h13;
                default: b = 8'h00;
            endcase
        end else begin
            case (idx)
                4'd0: b = 8'h08;
                4'd3: b = (kind == C_MSG_INVALID) ? 8'h01 : (kind == C_MSG_ACK) ? 8'h04 : 8'h03;
                4'd4: b = (kind == C_MSG_NONCE) ? n[31:24] : 8'h00;
                4'd5: b = (kind == C_MSG_NONCE) ? n[23:16] : 8'h00;
                4'd6: b = (kind == C_MSG_NONCE) ? n[15:8]  : 8'h00;
                4'd7: b = (kind == C_MSG_NONCE) ? n[7:0]   : 8'h00;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    function automatic logic [3:0] msg_last(input logic [2:0] kind);
        return (kind == C_MSG_PONG) ? 4'd0 : (kind == C_MSG_INFO) ? 4'd15 : 4'd7;
    endfunction

    // ---------------- RX byte receiver ----------------
    logic [1:0]  rx_sync_q;
    logic        rx_prev_q, rx_valid_q;
    logic [1:0]  rb_st_q;
    logic [15:0] rb_cnt_q;
    logic [2:0]  rb_bit_q;
    logic [7:0]  rb_sh_q;
    logic        w_rx;
    assign w_rx = rx_sync_q[1];

    always_ff @(posedge comm_clk) begin
        if (!rst_n) begin
            rx_sync_q <= 2'b11;  rx_prev_q <= 1'b1;  rx_valid_q <= 1'b0;
            rb_st_q   <= C_RB_IDLE; rb_cnt_q <= '0; rb_bit_q <= '0; rb_sh_q <= '0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], rx_serial};
            rx_prev_q  <= w_rx;
            rx_valid_q <= 1'b0;
            rb_cnt_q   <= rb_cnt_q + 16'd1;
            case (rb_st_q)
                C_RB_IDLE: if (rx_prev_q && !w_rx) begin rb_st_q <= C_RB_START; rb_cnt_q <= '0; end
                C_RB_START: if (rb_cnt_q == C_HALF - 16'd1) begin
                    rb_cnt_q <= '0; rb_bit_q <= '0;
                    rb_st_q  <= w_rx ? C_RB_IDLE : C_RB_DATA;
                end
                C_RB_DATA: if (rb_cnt_q == C_CPB - 16'd1) begin
                    rb_cnt_q <= '0;
                    rb_sh_q  <= {w_rx, rb_sh_q[7:1]};
                    rb_bit_q <= rb_bit_q + 3'd1;
                    if (rb_bit_q == 3'd7) rb_st_q <= C_RB_STOP;
                end
                default: if (rb_cnt_q == C_CPB - 16'd1) begin
                    rx_valid_q <= w_rx;
                    rb_st_q    <= C_RB_IDLE;
                end
            endcase
        end
    end

    // ---------------- Frame parser ----------------
    logic [2:0]   fs_q, req_kind_q, type_q;
    logic         req_q, hdr_bad_q, new_work_q;
    logic [7:0]   len_q, cnt_q;
    logic [31:0]  crc_q, rcv_crc_q;
    logic [415:0] job_q;
    logic [95:0]  work_data_q;
    logic [31:0]  nonce_min_q, nonce_max_q;
    logic [255:0] midstate_q;

    always_ff @(posedge comm_clk) begin
        if (!rst_n) begin
            fs_q <= C_FS_IDLE; req_q <= 1'b0; req_kind_q <= C_MSG_PONG; type_q <= '0;
            hdr_bad_q <= 1'b0; new_work_q <= 1'b0; len_q <= '0; cnt_q <= '0;
            crc_q <= '0; rcv_crc_q <= '0; job_q <= '0;
            work_data_q <= '0; nonce_min_q <= '0; nonce_max_q <= '0; midstate_q <= '0;
        end else begin
            req_q      <= 1'b0;
            new_work_q <= 1'b0;
            case (fs_q)
                C_FS_IDLE: if (rx_valid_q) begin
                    if (rb_sh_q == 8'h00) begin
                        req_q <= 1'b1; req_kind_q <= C_MSG_PONG;
                    end else if (rb_sh_q < 8'd8 || rb_sh_q > 8'd60 || rb_sh_q[1:0] != 2'b00) begin
                        req_q <= 1'b1; req_kind_q <= C_MSG_INVALID;
                    end else begin
                        len_q <= rb_sh_q; cnt_q <= 8'd1; hdr_bad_q <= 1'b0;
                        crc_q <= crc_upd(32'hFFFFFFFF, rb_sh_q);
                        fs_q  <= C_FS_HDR;
                    end
                end
                C_FS_HDR: if (rx_valid_q) begin
                    crc_q <= crc_upd(crc_q, rb_sh_q);
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q != 8'd3 && rb_sh_q != 8'h00) hdr_bad_q <= 1'b1;
                    if (cnt_q == 8'd3) begin
                        type_q <= (rb_sh_q == 8'h00) ? 3'd0 : (rb_sh_q == 8'h02) ? 3'd2 : 3'd7;
                        fs_q   <= (len_q == 8'd8) ? C_FS_CRC : C_FS_PAYLOAD;
                    end
                end
                C_FS_PAYLOAD: if (rx_valid_q) begin
                    crc_q <= crc_upd(crc_q, rb_sh_q);
                    job_q <= {rb_sh_q, job_q[415:8]};
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd5) fs_q <= C_FS_CRC;
                end
                C_FS_CRC: if (rx_valid_q) begin
                    rcv_crc_q <= {rb_sh_q, rcv_crc_q[31:8]};
                    cnt_q     <= cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) fs_q <= C_FS_DISPATCH;
                end
                default: begin
                    fs_q  <= C_FS_IDLE;
                    req_q <= 1'b1;
                    if (hdr_bad_q || (~crc_q != rcv_crc_q)) begin
                        req_kind_q <= C_MSG_INVALID;
                    end else if (type_q == 3'd0 && len_q == 8'd8) begin
                        req_kind_q <= C_MSG_INFO;
                    end else if (type_q == 3'd2 && len_q == 8'd60) begin
                        // Words arrive w0 first, so w0 ends up in the low bits of the shifter.
                        nonce_max_q <= job_q[31:0];
                        nonce_min_q <= job_q[63:32];
                        work_data_q <= job_q[159:64];
                        midstate_q  <= job_q[415:160];
                        new_work_q  <= 1'b1;
                        req_kind_q  <= C_MSG_ACK;
                    end else begin
                        req_kind_q <= C_MSG_INVALID;
                    end
                end
            endcase
        end
    end

    // ---------------- Reply arbitration and TX ----------------
    logic        rp_q, np_q, gn_prev_q, tx_q;
    logic [2:0]  rp_kind_q, tkind_q, tbit_q;
    logic [31:0] nval_q, tnonce_q;
    logic [1:0]  ts_q;
    logic [15:0] tcnt_q;
    logic [7:0]  tsh_q;
    logic [3:0]  tidx_q;
    logic        w_take_reply, w_take_nonce;
    assign w_take_reply = (ts_q == C_TS_IDLE) && rp_q;
    assign w_take_nonce = (ts_q == C_TS_IDLE) && !rp_q && np_q;

    always_ff @(posedge comm_clk) begin
        if (!rst_n) begin
            rp_q <= 1'b0; np_q <= 1'b0; gn_prev_q <= 1'b0; tx_q <= 1'b1;
            rp_kind_q <= C_MSG_PONG; tkind_q <= C_MSG_PONG; tbit_q <= '0;
            nval_q <= '0; tnonce_q <= '0; ts_q <= C_TS_IDLE; tcnt_q <= '0;
            tsh_q <= '0; tidx_q <= '0;
        end else begin
            gn_prev_q <= new_golden_nonce;
            if (req_q) begin
                rp_q <= 1'b1; rp_kind_q <= req_kind_q;
            end else if (w_take_reply) begin
                rp_q <= 1'b0;
            end
            if (new_golden_nonce && !gn_prev_q) begin
                np_q <= 1'b1; nval_q <= golden_nonce;
            end else if (w_take_nonce) begin
                np_q <= 1'b0;
            end
            tcnt_q <= tcnt_q + 16'd1;
            case (ts_q)
                C_TS_IDLE: if (w_take_reply || w_take_nonce) begin
                    tkind_q  <= w_take_reply ? rp_kind_q : C_MSG_NONCE;
                    tnonce_q <= nval_q;
                    tsh_q    <= msg_byte(w_take_reply ? rp_kind_q : C_MSG_NONCE, 4'd0, nval_q);
                    tidx_q   <= '0; tcnt_q <= '0; tx_q <= 1'b0;
                    ts_q     <= C_TS_START;
                end
                C_TS_START: if (tcnt_q == C_CPB - 16'd1) begin
                    tcnt_q <= '0; tbit_q <= '0; tx_q <= tsh_q[0];
                    ts_q   <= C_TS_DATA;
                end
                C_TS_DATA: if (tcnt_q == C_CPB - 16'd1) begin
                    tcnt_q <= '0;
                    if (tbit_q == 3'd7) begin
                        tx_q <= 1'b1; ts_q <= C_TS_STOP;
                    end else begin
                        tx_q <= tsh_q[1]; tsh_q <= tsh_q >> 1; tbit_q <= tbit_q + 3'd1;
                    end
                end
                default: if (tcnt_q == C_CPB - 16'd1) begin
                    tcnt_q <= '0;
                    if (tidx_q == msg_last(tkind_q)) begin
                        ts_q <= C_TS_IDLE;
                    end else begin
                        tidx_q <= tidx_q + 4'd1;
                        tsh_q  <= msg_byte(tkind_q, tidx_q + 4'd1, tnonce_q);
                        tx_q   <= 1'b0; ts_q <= C_TS_START;
                    end
                end
            endcase
        end
    end

    assign tx_serial = tx_q;
    assign new_work  = new_work_q;
    assign work_data = work_data_q;
    assign nonce_min = nonce_min_q;
    assign nonce_max = nonce_max_q;
    assign midstate  = midstate_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_miner_comm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_miner_comm
//  Description : Self-checking bench for uart_miner_comm, 16 clocks per bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_miner_comm;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx = 1'b1;
    logic         tx;
    logic         nw;
    logic [95:0]  wd;
    logic [31:0]  nmin, nmax;
    logic [255:0] ms;
    logic         gn = 1'b0;
    logic [31:0]  gnv = '0;

    int checks = 0;
    int errors = 0;
    int nw_cnt = 0;
    bit mon_en = 1'b0;
    logic [7:0] exp_q[$];

    typedef struct packed {
        logic [15:0][7:0] frm;
        logic [7:0]       flen;
        logic [15:0][7:0] rep;
        logic [7:0]       rlen;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    uart_miner_comm #(.BAUD_RATE(100), .SYS_CLK_FREQ(1600)) dut (
        .comm_clk(clk), .rst_n(rst_n), .rx_serial(rx), .tx_serial(tx),
        .new_work(nw), .work_data(wd), .nonce_min(nmin), .nonce_max(nmax),
        .midstate(ms), .new_golden_nonce(gn), .golden_nonce(gnv)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // 8-byte command frame with a correct trailing CRC and its expected reply.
    function automatic vec_t mk_cmd(input logic [7:0] b1, input logic [7:0] typ, input bit info);
        vec_t v;
        logic [31:0]  c;
        logic [127:0] info_v;
        logic [63:0]  inv_v;
        info_v = 128'h10000000deadbeef13370d1300000000;
        inv_v  = 64'h0800000100000000;
        v = '0;
        v.frm[0] = 8'h08; v.frm[1] = b1; v.frm[2] = 8'h00; v.frm[3] = typ;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) c = crc_upd(c, v.frm[i]);
        c = ~c;
        for (int k = 0; k < 4; k++) v.frm[4+k] = c[8*k +: 8];
        v.flen = 8'd8;
        if (info) begin
            for (int k = 0; k < 16; k++) v.rep[k] = info_v[127-8*k -: 8];
            v.rlen = 8'd16;
        end else begin
            for (int k = 0; k < 8; k++) v.rep[k] = inv_v[63-8*k -: 8];
            v.rlen = 8'd8;
        end
        return v;
    endfunction

    function automatic vec_t mk_lone(input logic [7:0] b);
        vec_t v;
        v = mk_cmd(8'h00, 8'h05, 1'b0);
        v.frm = '0; v.frm[0] = b; v.flen = 8'd1;
        if (b == 8'h00) begin v.rep = '0; v.rep[0] = 8'h01; v.rlen = 8'd1; end
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx = 1'b0; repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (16) @(negedge clk); end
        rx = 1'b1; repeat (16) @(negedge clk);
    endtask

    task automatic push_bytes(input logic [63:0] v);
        for (int k = 0; k < 8; k++) exp_q.push_back(v[63-8*k -: 8]);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d bytes still expected, 0 required", exp_q.size());
            exp_q.delete();
        end
        repeat (40) @(negedge clk);
    endtask

    // Scoreboard side: decode each byte on tx and compare with the queue head.
    initial begin
        logic [7:0] b;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                repeat (8) @(negedge clk);
                chk("tx_start_bit", {255'h0, tx}, 256'h0);
                for (int i = 0; i < 8; i++) begin repeat (16) @(negedge clk); b[i] = tx; end
                repeat (16) @(negedge clk);
                chk("tx_stop_bit", {255'h0, tx}, 256'h1);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected_byte: got %02h required none", b);
                end else begin
                    e = exp_q.pop_front();
                    if (b !== e) begin
                        errors++;
                        $display("FAIL tx_byte: got %02h required %02h", b, e);
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (nw === 1'b1) nw_cnt++;
    end

    initial begin
        logic [7:0]  job [60];
        logic [31:0] c;
        int n;
        vec_t bad;

        vecs[0] = mk_lone(8'h00);
        vecs[1] = mk_cmd(8'h00, 8'h00, 1'b1);
        vecs[2] = mk_lone(8'h06);
        vecs[3] = mk_cmd(8'h00, 8'h00, 1'b1);
        vecs[4] = mk_cmd(8'h00, 8'h05, 1'b0);
        vecs[5] = mk_cmd(8'h01, 8'h00, 1'b0);
        vecs[6] = mk_lone(8'h40);
        vecs[7] = mk_cmd(8'h00, 8'h02, 1'b0);

        repeat (5) @(negedge clk);
        chk("reset_tx", {255'h0, tx}, 256'h1);
        chk("reset_new_work", {255'h0, nw}, 256'h0);
        chk("reset_work_data", {160'h0, wd}, 256'h0);
        chk("reset_midstate", ms, 256'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        mon_en = 1'b1;

        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < int'(vecs[v].rlen); i++) exp_q.push_back(vecs[v].rep[i]);
            for (int i = 0; i < int'(vecs[v].flen); i++) send_byte(vecs[v].frm[i]);
            wait_drain(6000);
        end
        chk("no_work_from_table", nw_cnt, 0);

        // PUSH_JOB followed by a golden nonce raised mid-ACK and held high.
        job[0] = 8'h3c; job[1] = 8'h00; job[2] = 8'h00; job[3] = 8'h02;
        for (int p = 0; p < 52; p++)
            job[4+p] = (p < 4) ? 8'h00 : (p < 8) ? ((p == 7) ? 8'h1f : 8'hff) : 8'(p);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 56; i++) c = crc_upd(c, job[i]);
        c = ~c;
        for (int k = 0; k < 4; k++) job[56+k] = c[8*k +: 8];
        push_bytes(64'h0800000400000000);
        for (int i = 0; i < 60; i++) send_byte(job[i]);
        n = 0;
        while (tx !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        chk("ack_started", {255'h0, tx}, 256'h0);
        repeat (300) @(negedge clk);
        gnv = 32'h38b9b05a; gn = 1'b1;
        push_bytes(64'h0800000338b9b05a);
        wait_drain(6000);
        repeat (1500) @(negedge clk);
        gn = 1'b0;
        chk("push_new_work_pulses", nw_cnt, 1);
        chk("push_nonce_min", {224'h0, nmin}, 256'h1fffffff);
        chk("push_nonce_max", {224'h0, nmax}, 256'h0);
        chk("push_work_data", {160'h0, wd}, 256'h131211100f0e0d0c0b0a0908);
        chk("push_midstate", ms, 256'h333231302f2e2d2c2b2a292827262524232221201f1e1d1c1b1a191817161514);

        // GET_INFO with a corrupted CRC bit.
        bad = mk_cmd(8'h00, 8'h00, 1'b1);
        bad.frm[5] = bad.frm[5] ^ 8'h08;
        push_bytes(64'h0800000100000000);
        for (int i = 0; i < 8; i++) send_byte(bad.frm[i]);
        wait_drain(6000);
        chk("badcrc_no_work", nw_cnt, 1);
        chk("badcrc_nonce_min", {224'h0, nmin}, 256'h1fffffff);
        chk("badcrc_midstate", ms, 256'h333231302f2e2d2c2b2a292827262524232221201f1e1d1c1b1a191817161514);

        // Reset in the middle of an incoming length byte.
        rx = 1'b0; repeat (16) @(negedge clk);
        rx = 1'b0; repeat (40) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        chk("midreset_tx", {255'h0, tx}, 256'h1);
        chk("midreset_new_work", {255'h0, nw}, 256'h0);
        chk("midreset_nonce_min", {224'h0, nmin}, 256'h0);
        chk("midreset_work_data", {160'h0, wd}, 256'h0);
        chk("midreset_midstate", ms, 256'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        exp_q.push_back(8'h01);
        send_byte(8'h00);
        wait_drain(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
